// File: rtl/alu_pkg.sv
// Shared types and helpers for the registered ALU: opcodes, flag bundle,
// controller states and the result-derived flag function.
package alu_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 64;

    typedef enum logic [7:0] {
        OP_ADD  = 8'h00,
        OP_SUB  = 8'h01,
        OP_MUL  = 8'h02,
        OP_EQ   = 8'h03,
        OP_GT   = 8'h04,
        OP_ADDI = 8'h09,
        OP_SUBI = 8'h0A,
        OP_MOV  = 8'h0B
    } opcode_t;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
        logic sign;
        logic parity;
    } alu_flags_t;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_t;

    // Caller zero-extends the result; width selects which bit is the sign.
    function automatic alu_flags_t result_flags(input logic [MAX_DATA_WIDTH-1:0] res,
                                                input int unsigned width);
        logic [MAX_DATA_WIDTH-1:0] shifted;
        alu_flags_t                f;
        shifted    = res >> (width - 32'd1);
        f.overflow = 1'b0;
        f.carry    = 1'b0;
        f.zero     = (res == {MAX_DATA_WIDTH{1'b0}});
        f.sign     = shifted[0];
        f.parity   = ^res;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Signed shift-add multiplier, one multiplier bit per cycle; the final step
// subtracts because the multiplier MSB carries negative weight.
module alu_mul_seq #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [PW-1:0]         acc_r;
    logic [PW-1:0]         mcand_r;
    logic [DATA_WIDTH-1:0] mplier_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  busy_r;
    logic [PW-1:0]         partial_s;
    logic [PW-1:0]         acc_next_s;
    logic                  last_step_s;

    // Partial product for the current multiplier bit
    always_comb begin
        partial_s   = mplier_r[0] ? mcand_r : {PW{1'b0}};
        last_step_s = (count_r == CNT_WIDTH'(1));
        if (last_step_s) begin
            acc_next_s = acc_r - partial_s;
        end else begin
            acc_next_s = acc_r + partial_s;
        end
    end

    // Iteration registers: load on start, step while count is non-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {DATA_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {{DATA_WIDTH{op_a[DATA_WIDTH-1]}}, op_a};
            mplier_r <= op_b;
            count_r  <= CNT_WIDTH'(DATA_WIDTH);
            busy_r   <= 1'b1;
        end else if (busy_r && (count_r != {CNT_WIDTH{1'b0}})) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[PW-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[DATA_WIDTH-1:1]};
            count_r  <= count_r - CNT_WIDTH'(1);
        end else if (busy_r) begin
            busy_r   <= 1'b0;
        end
    end

    assign done    = busy_r && (count_r == {CNT_WIDTH{1'b0}});
    assign product = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, one-entry output register and a
// sequential signed multiplier for MUL.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  enable_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [7:0]            opcode_in,
    input  logic [DATA_WIDTH-1:0] alu_input1,
    input  logic [DATA_WIDTH-1:0] alu_input2,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] alu_output,
    output logic                  overflow_flag,
    output logic                  carry_flag,
    output logic                  zero_flag,
    output logic                  sign_flag,
    output logic                  parity_flag
);

    localparam int unsigned W = DATA_WIDTH;

    alu_state_t        state_r, state_next_s;
    logic              ready_s, accept_s, is_mul_s, mul_start_s, mul_done_s, load_s;
    logic [2*W-1:0]    mul_product_s;
    logic [W-1:0]      mul_result_s, op_result_s, load_result_s;
    logic [W:0]        sum_s, diff_s;
    logic              op_ov_s, op_carry_s;
    alu_flags_t        op_flags_s, mul_flags_s, load_flags_s, flags_r;
    logic [W-1:0]      result_r;
    logic              valid_r;

    assign ready_s  = enable_in && (state_r == ST_IDLE) && (!valid_r || ready_in);
    assign accept_s = valid_in && ready_s;
    assign is_mul_s = (opcode_in == OP_MUL);
    assign sum_s    = {1'b0, alu_input1} + {1'b0, alu_input2};
    assign diff_s   = {1'b0, alu_input1} - {1'b0, alu_input2};

    alu_mul_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_mul (
        .clk     (clk_in),
        .rst_n   (reset_n_in),
        .start   (mul_start_s),
        .op_a    (alu_input1),
        .op_b    (alu_input2),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Single-cycle datapath; MUL and unknown opcodes yield 0 here
    always_comb begin
        op_result_s = {W{1'b0}};
        op_ov_s     = 1'b0;
        op_carry_s  = 1'b0;
        case (opcode_t'(opcode_in))
            OP_ADD, OP_ADDI: begin
                op_result_s = sum_s[W-1:0];
                op_carry_s  = sum_s[W];
                op_ov_s     = (alu_input1[W-1] == alu_input2[W-1]) &&
                              (sum_s[W-1] != alu_input1[W-1]);
            end
            OP_SUB, OP_SUBI: begin
                op_result_s = diff_s[W-1:0];
                op_carry_s  = diff_s[W];
                op_ov_s     = (alu_input1[W-1] != alu_input2[W-1]) &&
                              (diff_s[W-1] != alu_input1[W-1]);
            end
            OP_EQ:   op_result_s = {{(W-1){1'b0}}, (alu_input1 == alu_input2)};
            OP_GT:   op_result_s = {{(W-1){1'b0}}, ($signed(alu_input1) > $signed(alu_input2))};
            OP_MOV:  op_result_s = alu_input1;
            default: op_result_s = {W{1'b0}};
        endcase
        op_flags_s          = result_flags(MAX_DATA_WIDTH'(op_result_s), W);
        op_flags_s.overflow = op_ov_s;
        op_flags_s.carry    = op_carry_s;
    end

    // Product truncation: overflow when the high half is not a sign extension
    always_comb begin
        mul_result_s         = mul_product_s[W-1:0];
        mul_flags_s          = result_flags(MAX_DATA_WIDTH'(mul_result_s), W);
        mul_flags_s.overflow = (mul_product_s[2*W-1:W] != {W{mul_result_s[W-1]}});
        mul_flags_s.carry    = mul_flags_s.overflow;
    end

    // Controller next state and output-register load selection
    always_comb begin
        state_next_s  = state_r;
        mul_start_s   = 1'b0;
        load_s        = 1'b0;
        load_result_s = op_result_s;
        load_flags_s  = op_flags_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    mul_start_s  = 1'b1;
                    state_next_s = ST_MUL_BUSY;
                end else if (accept_s) begin
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done_s) begin
                    load_s        = 1'b1;
                    load_result_s = mul_result_s;
                    load_flags_s  = mul_flags_s;
                    state_next_s  = ST_IDLE;
                end else begin
                    state_next_s  = ST_MUL_BUSY;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // One-entry output register; a load may coincide with the consume
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            valid_r  <= 1'b0;
            result_r <= {W{1'b0}};
            flags_r  <= '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else if (load_s) begin
            valid_r  <= 1'b1;
            result_r <= load_result_s;
            flags_r  <= load_flags_s;
        end else if (valid_r && ready_in) begin
            valid_r  <= 1'b0;
        end
    end

    assign ready_out     = ready_s;
    assign valid_out     = valid_r;
    assign alu_output    = result_r;
    assign overflow_flag = flags_r.overflow;
    assign carry_flag    = flags_r.carry;
    assign zero_flag     = flags_r.zero;
    assign sign_flag     = flags_r.sign;
    assign parity_flag   = flags_r.parity;

endmodule
